// File: rtl/ps2_cmd_decoder_pkg.sv
// Shared constants for the PS/2 command decoder: command bit indices,
// set-2 scan codes and the prefix-tracking FSM state type.
package ps2_cmd_decoder_pkg;

  // Command bus widths
  localparam int WIN_CTRL_CMD  = 7;
  localparam int ENVO_CTRL_CMD = 8;

  // win_ctrl_cmd bit indices
  localparam int M_UP    = 0;
  localparam int M_DOWN  = 1;
  localparam int M_LEFT  = 2;
  localparam int M_RIGHT = 3;
  localparam int Z_IN    = 4;
  localparam int Z_OUT   = 5;
  localparam int M_MODE  = 6;

  // envo_ctrl_cmd bit indices (bits 7:6 unused)
  localparam int CLR           = 0;
  localparam int INC_V         = 1;
  localparam int DEC_V         = 2;
  localparam int CUR_USER_DATA = 3;
  localparam int CUR_USER_SET  = 4;
  localparam int RANDOM        = 5;

  // Prefix bytes
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Key scan codes (the first four only count with the E0 prefix)
  localparam logic [7:0] KEY_UP        = 8'h75;
  localparam logic [7:0] KEY_DOWN      = 8'h72;
  localparam logic [7:0] KEY_LEFT      = 8'h6B;
  localparam logic [7:0] KEY_RIGHT     = 8'h74;
  localparam logic [7:0] KEY_ZIN       = 8'h55;
  localparam logic [7:0] KEY_ZOUT      = 8'h4E;
  localparam logic [7:0] KEY_MODE      = 8'h3A;
  localparam logic [7:0] KEY_CLR       = 8'h21;
  localparam logic [7:0] KEY_INC_V     = 8'h5B;
  localparam logic [7:0] KEY_DEC_V     = 8'h54;
  localparam logic [7:0] KEY_USER_DATA = 8'h23;
  localparam logic [7:0] KEY_USER_SET  = 8'h29;
  localparam logic [7:0] KEY_RANDOM    = 8'h2D;

  localparam int NUM_KEYS = 13;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  typedef struct packed {
    logic [WIN_CTRL_CMD-1:0]  win;
    logic [ENVO_CTRL_CMD-1:0] envo;
  } cmd_t;

  // One-hot command word for a key-map index
  function automatic cmd_t key_cmd(input logic [3:0] idx);
    cmd_t c;
    c = '0;
    case (idx)
      4'd0:  c.win[M_UP]            = 1'b1;
      4'd1:  c.win[M_DOWN]          = 1'b1;
      4'd2:  c.win[M_LEFT]          = 1'b1;
      4'd3:  c.win[M_RIGHT]         = 1'b1;
      4'd4:  c.win[Z_IN]            = 1'b1;
      4'd5:  c.win[Z_OUT]           = 1'b1;
      4'd6:  c.win[M_MODE]          = 1'b1;
      4'd7:  c.envo[CLR]            = 1'b1;
      4'd8:  c.envo[INC_V]          = 1'b1;
      4'd9:  c.envo[DEC_V]          = 1'b1;
      4'd10: c.envo[CUR_USER_DATA]  = 1'b1;
      4'd11: c.envo[CUR_USER_SET]   = 1'b1;
      4'd12: c.envo[RANDOM]         = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ps2_cmd_decoder.sv
// Turns PS/2 set-2 scan-code bytes into single-cycle command pulses.
// Tracks E0/F0 prefixes, suppresses typematic repeat with a held mask and
// abandons a half-received sequence after TIMEOUT_CYC idle cycles.
//
// Input handshake: a byte is offered by raising ps2_state with ps2_byte
// stable; one rising edge of ps2_state is one byte regardless of how long
// the level stays high. Outputs are registered; a command pulse and
// key_valid appear two cycles after the sampled rising edge, for one cycle.
module ps2_cmd_decoder
  import ps2_cmd_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               ps2_byte,
  input  logic                     ps2_state,
  output logic [WIN_CTRL_CMD-1:0]  win_ctrl_cmd,
  output logic [ENVO_CTRL_CMD-1:0] envo_ctrl_cmd,
  output logic                     key_valid,
  output logic [7:0]               last_code
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  logic                ps2_state_q;
  logic                strb_q;
  logic [7:0]          byte_q;
  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [NUM_KEYS-1:0] held_q;

  logic                ext;
  logic                is_make;
  logic                key_hit;
  logic [3:0]          key_idx;
  cmd_t                cmd;

  // Rising-edge detect on the byte flag; byte captured alongside the edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps2_state_q <= 1'b0;
      strb_q      <= 1'b0;
      byte_q      <= 8'h00;
    end else begin
      ps2_state_q <= ps2_state;
      strb_q      <= ps2_state & ~ps2_state_q;
      byte_q      <= ps2_byte;
    end
  end

  // Key-map lookup; extended and plain forms of a code are distinct keys
  always_comb begin
    ext     = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    is_make = (state_q == ST_IDLE) || (state_q == ST_EXT);
    key_hit = 1'b1;
    key_idx = 4'd0;
    case ({ext, byte_q})
      {1'b1, KEY_UP}:        key_idx = 4'd0;
      {1'b1, KEY_DOWN}:      key_idx = 4'd1;
      {1'b1, KEY_LEFT}:      key_idx = 4'd2;
      {1'b1, KEY_RIGHT}:     key_idx = 4'd3;
      {1'b0, KEY_ZIN}:       key_idx = 4'd4;
      {1'b0, KEY_ZOUT}:      key_idx = 4'd5;
      {1'b0, KEY_MODE}:      key_idx = 4'd6;
      {1'b0, KEY_CLR}:       key_idx = 4'd7;
      {1'b0, KEY_INC_V}:     key_idx = 4'd8;
      {1'b0, KEY_DEC_V}:     key_idx = 4'd9;
      {1'b0, KEY_USER_DATA}: key_idx = 4'd10;
      {1'b0, KEY_USER_SET}:  key_idx = 4'd11;
      {1'b0, KEY_RANDOM}:    key_idx = 4'd12;
      default:               key_hit = 1'b0;
    endcase
    cmd = key_cmd(key_idx);
  end

  // Prefix FSM, timeout, held mask and registered command outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      held_q        <= '0;
      win_ctrl_cmd  <= '0;
      envo_ctrl_cmd <= '0;
      key_valid     <= 1'b0;
      last_code     <= 8'h00;
    end else begin
      win_ctrl_cmd  <= '0;
      envo_ctrl_cmd <= '0;
      key_valid     <= 1'b0;
      if (strb_q) begin
        // A byte always wins over a coincident timeout
        cnt_q <= '0;
        if (byte_q == PS2_EXT) begin
          state_q <= ST_EXT;
        end else if (byte_q == PS2_BRK) begin
          if (state_q == ST_IDLE)     state_q <= ST_BRK;
          else if (state_q == ST_EXT) state_q <= ST_EXT_BRK;
        end else begin
          state_q <= ST_IDLE;
          if (byte_q != PS2_PAUSE && key_hit) begin
            if (is_make) begin
              if (!held_q[key_idx]) begin
                held_q[key_idx] <= 1'b1;
                win_ctrl_cmd    <= cmd.win;
                envo_ctrl_cmd   <= cmd.envo;
                key_valid       <= 1'b1;
                last_code       <= byte_q;
              end
            end else begin
              held_q[key_idx] <= 1'b0;
            end
          end
        end
      end else if (state_q != ST_IDLE) begin
        if (cnt_q == CNT_LAST) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Directed bench for ps2_cmd_decoder with an expected-pulse queue.
module tb_ps2_cmd_decoder;

  localparam int TO = 50;

  logic       clk;
  logic       rst;
  logic [7:0] ps2_byte;
  logic       ps2_state;
  logic [6:0] win_ctrl_cmd;
  logic [7:0] envo_ctrl_cmd;
  logic       key_valid;
  logic [7:0] last_code;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // {cycle[15:0], code[7:0], envo[7:0], win[6:0]}
  logic [38:0] exp_q[$];

  ps2_cmd_decoder #(.TIMEOUT_CYC(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .ps2_byte      (ps2_byte),
    .ps2_state     (ps2_state),
    .win_ctrl_cmd  (win_ctrl_cmd),
    .envo_ctrl_cmd (envo_ctrl_cmd),
    .key_valid     (key_valid),
    .last_code     (last_code)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send one byte; when a pulse is expected, queue it for two cycles after
  // the sampling edge of the rising ps2_state.
  task automatic send_byte(input logic [7:0] b, input logic en,
                           input logic [6:0] w, input logic [7:0] e);
    @(posedge clk);
    #1;
    ps2_byte  = b;
    ps2_state = 1'b1;
    if (en) exp_q.push_back({16'(cyc + 2), b, e, w});
    idle(3);
    ps2_state = 1'b0;
    ps2_byte  = 8'($urandom_range(0, 255));
    idle(3);
  endtask

  // Scoreboard: every pulse must match the head of the queue in value and cycle
  always @(negedge clk) begin
    logic [38:0] e;
    check("kv_vs_cmd", {31'd0, key_valid}, {31'd0, (|win_ctrl_cmd) | (|envo_ctrl_cmd)});
    check("onehot", $countones({win_ctrl_cmd, envo_ctrl_cmd}) <= 1, 1);
    if (key_valid) begin
      check("pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("win",   {25'd0, win_ctrl_cmd}, {25'd0, e[6:0]});
        check("envo",  {24'd0, envo_ctrl_cmd}, {24'd0, e[14:7]});
        check("code",  {24'd0, last_code}, {24'd0, e[22:15]});
        check("cycle", {16'd0, cyc[15:0]}, {16'd0, e[38:23]});
      end
    end
  end

  initial begin
    rst       = 1'b0;
    ps2_byte  = 8'h00;
    ps2_state = 1'b0;
    idle(4);
    check("rst_win",  {25'd0, win_ctrl_cmd}, 0);
    check("rst_envo", {24'd0, envo_ctrl_cmd}, 0);
    check("rst_kv",   {31'd0, key_valid}, 0);
    check("rst_code", {24'd0, last_code}, 0);
    rst = 1'b1;
    idle(3);

    // Unmapped then RANDOM
    send_byte(8'h1D, 1'b0, 7'd0, 8'd0);
    send_byte(8'h2D, 1'b1, 7'd0, 8'b0010_0000);
    idle(5);
    check("code_hold", {24'd0, last_code}, 32'h2D);

    // Extended up, its break, then up again
    send_byte(8'hE0, 1'b0, 7'd0, 8'd0);
    send_byte(8'h75, 1'b1, 7'b000_0001, 8'd0);
    send_byte(8'hE0, 1'b0, 7'd0, 8'd0);
    send_byte(8'hF0, 1'b0, 7'd0, 8'd0);
    send_byte(8'h75, 1'b0, 7'd0, 8'd0);
    send_byte(8'hE0, 1'b0, 7'd0, 8'd0);
    send_byte(8'h75, 1'b1, 7'b000_0001, 8'd0);

    // Typematic repeat on space, release, press again
    send_byte(8'h29, 1'b1, 7'd0, 8'b0001_0000);
    send_byte(8'h29, 1'b0, 7'd0, 8'd0);
    send_byte(8'h29, 1'b0, 7'd0, 8'd0);
    send_byte(8'hF0, 1'b0, 7'd0, 8'd0);
    send_byte(8'h29, 1'b0, 7'd0, 8'd0);
    send_byte(8'h29, 1'b1, 7'd0, 8'b0001_0000);

    // Stale break prefix times out; next byte is a make
    send_byte(8'hF0, 1'b0, 7'd0, 8'd0);
    idle(TO + 5);
    send_byte(8'h21, 1'b1, 7'd0, 8'b0000_0001);

    // Plain 75 unmapped; E0 55 unmapped; plain 55 then works from IDLE
    send_byte(8'h75, 1'b0, 7'd0, 8'd0);
    send_byte(8'hE0, 1'b0, 7'd0, 8'd0);
    send_byte(8'h55, 1'b0, 7'd0, 8'd0);
    send_byte(8'h55, 1'b1, 7'b001_0000, 8'd0);

    // Pause byte drops the extended prefix
    send_byte(8'hE0, 1'b0, 7'd0, 8'd0);
    send_byte(8'hE1, 1'b0, 7'd0, 8'd0);
    send_byte(8'h72, 1'b0, 7'd0, 8'd0);

    // Remaining keys
    send_byte(8'hE0, 1'b0, 7'd0, 8'd0);
    send_byte(8'h72, 1'b1, 7'b000_0010, 8'd0);
    send_byte(8'hE0, 1'b0, 7'd0, 8'd0);
    send_byte(8'h6B, 1'b1, 7'b000_0100, 8'd0);
    send_byte(8'hE0, 1'b0, 7'd0, 8'd0);
    send_byte(8'h74, 1'b1, 7'b000_1000, 8'd0);
    send_byte(8'h4E, 1'b1, 7'b010_0000, 8'd0);
    send_byte(8'h3A, 1'b1, 7'b100_0000, 8'd0);
    send_byte(8'h5B, 1'b1, 7'd0, 8'b0000_0010);
    send_byte(8'h54, 1'b1, 7'd0, 8'b0000_0100);
    send_byte(8'h23, 1'b1, 7'd0, 8'b0000_1000);
    idle(5);
    check("code_last", {24'd0, last_code}, 32'h23);

    // Reset between E0 and 6B clears everything
    send_byte(8'hE0, 1'b0, 7'd0, 8'd0);
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(2);
    send_byte(8'h6B, 1'b0, 7'd0, 8'd0);
    idle(5);
    check("post_rst_code", {24'd0, last_code}, 0);
    check("post_rst_win",  {25'd0, win_ctrl_cmd}, 0);
    check("post_rst_envo", {24'd0, envo_ctrl_cmd}, 0);
    // Held mask was cleared: space pulses again without a break
    send_byte(8'h29, 1'b1, 7'd0, 8'b0001_0000);

    idle(10);
    check("leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
